// File: rtl/onchip_load_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_load_sequencer_if
//  Brief    : Handshake / address bundle between a load controller, the
//             off-chip/on-chip RAM pair and onchip_load_sequencer.
//             Optional macro LOAD_SRC_STRIDE_EN adds the SrcStride signal.
//  Revision : 1.0  initial release
// ============================================================================
interface onchip_load_sequencer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 16
);
    logic                     Start;
    logic [ADDRESS_WIDTH-1:0] SrcBase;
    logic [ADDRESS_WIDTH-1:0] DstBase;
    logic [LEN_WIDTH-1:0]     Length;
    logic                     Stall;
`ifdef LOAD_SRC_STRIDE_EN
    logic [ADDRESS_WIDTH-1:0] SrcStride;
`endif
    logic [ADDRESS_WIDTH-1:0] Off_RAddr;
    logic [ADDRESS_WIDTH-1:0] On_WAddr;
    logic                     On_WEn;
    logic                     Busy;
    logic                     Done;

`ifdef LOAD_SRC_STRIDE_EN
    // Controller side: starts transfers, observes RAM addresses and status
    modport master (
        output Start, SrcBase, DstBase, Length, Stall, SrcStride,
        input  Off_RAddr, On_WAddr, On_WEn, Busy, Done
    );
    // Sequencer side
    modport slave (
        input  Start, SrcBase, DstBase, Length, Stall, SrcStride,
        output Off_RAddr, On_WAddr, On_WEn, Busy, Done
    );
`else
    // Controller side: starts transfers, observes RAM addresses and status
    modport master (
        output Start, SrcBase, DstBase, Length, Stall,
        input  Off_RAddr, On_WAddr, On_WEn, Busy, Done
    );
    // Sequencer side
    modport slave (
        input  Start, SrcBase, DstBase, Length, Stall,
        output Off_RAddr, On_WAddr, On_WEn, Busy, Done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/onchip_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_load_sequencer
//  Brief    : Copies one tile of Length words from an off-chip RAM to an
//             on-chip RAM. Drives the off-chip read address and a delayed
//             on-chip write address/enable that lines up with the off-chip
//             RAM's registered read data (READ_LATENCY cycles later).
//             Optional macro LOAD_SRC_STRIDE_EN: strided source addressing.
//  Revision : 1.0  initial release
// ============================================================================
module onchip_load_sequencer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int READ_LATENCY  = 1     // legal range 1..4
) (
    input  wire logic               clk,
    input  wire logic               aclr,
    onchip_load_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_accept;
    logic                     w_issue;

    logic [ADDRESS_WIDTH-1:0] r_dst_base;
    logic [LEN_WIDTH-1:0]     r_len;
    logic [LEN_WIDTH-1:0]     r_cnt;
    logic [ADDRESS_WIDTH-1:0] w_src_addr;
    logic [ADDRESS_WIDTH-1:0] w_dst_addr;

    // Stage 0 is the issue register; further stages cover the extra RAM latency
    logic [READ_LATENCY-1:0]  r_vld;
    logic [ADDRESS_WIDTH-1:0] r_daddr [READ_LATENCY];

    logic [ADDRESS_WIDTH-1:0] r_off_raddr;
    logic [ADDRESS_WIDTH-1:0] r_on_waddr;
    logic                     r_on_wen;

    assign w_dst_addr = r_dst_base + ADDRESS_WIDTH'(r_cnt);

    // State register
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus accept/issue strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (bus.Length != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (!bus.Stall) begin
                    w_issue = 1'b1;
                    if (r_cnt == r_len - LEN_WIDTH'(1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last stage's valid becomes next cycle's On_WEn, so an
                // empty delay line means the final write is happening now and
                // Done lands on the cycle right after it.
                if (r_vld == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Transfer parameters and word counter
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_dst_base <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_dst_base <= bus.DstBase;
            r_len      <= bus.Length;
            r_cnt      <= '0;
        end else if (w_issue) begin
            r_cnt      <= r_cnt + LEN_WIDTH'(1);
        end
    end

`ifdef LOAD_SRC_STRIDE_EN
    logic [ADDRESS_WIDTH-1:0] r_src_acc;
    logic [ADDRESS_WIDTH-1:0] r_stride;

    // Source address accumulator, advanced by the stride on every issue
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_src_acc <= '0;
            r_stride  <= '0;
        end else if (w_accept) begin
            r_src_acc <= bus.SrcBase;
            r_stride  <= bus.SrcStride;
        end else if (w_issue) begin
            r_src_acc <= r_src_acc + r_stride;
        end
    end

    assign w_src_addr = r_src_acc;
`else
    logic [ADDRESS_WIDTH-1:0] r_src_base;

    // Latched source base; contiguous source addresses come from the counter
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_src_base <= '0;
        end else if (w_accept) begin
            r_src_base <= bus.SrcBase;
        end
    end

    assign w_src_addr = r_src_base + ADDRESS_WIDTH'(r_cnt);
`endif

    // Read issue and destination delay line; shifts every cycle so stalls
    // insert bubbles instead of freezing reads already in flight
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_off_raddr <= '0;
            r_vld       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_daddr[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            if (w_issue) begin
                r_off_raddr <= w_src_addr;
                r_daddr[0]  <= w_dst_addr;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_daddr[i] <= r_daddr[i-1];
            end
        end
    end

    // On-chip write port; address holds its last value between writes
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_on_wen   <= 1'b0;
            r_on_waddr <= '0;
        end else begin
            r_on_wen <= r_vld[READ_LATENCY-1];
            if (r_vld[READ_LATENCY-1]) begin
                r_on_waddr <= r_daddr[READ_LATENCY-1];
            end
        end
    end

    assign bus.Off_RAddr = r_off_raddr;
    assign bus.On_WAddr  = r_on_waddr;
    assign bus.On_WEn    = r_on_wen;
    assign bus.Busy      = (r_state != IDLE);
    assign bus.Done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_onchip_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_load_sequencer
//  Brief    : Directed self-checking bench for onchip_load_sequencer with a
//             one-cycle registered off-chip RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_onchip_load_sequencer;

    localparam int AW = 32;
    localparam int LW = 16;
    localparam int RL = 1;

    logic clk  = 1'b0;
    logic aclr = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    onchip_load_sequencer_if #(.ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    onchip_load_sequencer #(
        .ADDRESS_WIDTH (AW),
        .LEN_WIDTH     (LW),
        .READ_LATENCY  (RL)
    ) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    // Off-chip RAM contents: word at address a is {a[15:0], ~a[15:0]}
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] q;
    always @(posedge clk) q <= ram_word(bus.Off_RAddr);

    // Per-cycle trace; index c is the sample taken 1 ns after edge c,
    // edge 0 being the edge that accepts Start
    logic [31:0] tr_off [16];
    logic [31:0] tr_wa  [16];
    logic [31:0] tr_q   [16];
    logic [15:0] tr_we, tr_done, tr_busy;

    task automatic capture(input int n, input logic [15:0] stall_mask,
                           input logic [15:0] start_mask);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            tr_off[c]  = bus.Off_RAddr;
            tr_wa[c]   = bus.On_WAddr;
            tr_q[c]    = q;
            tr_we[c]   = bus.On_WEn;
            tr_done[c] = bus.Done;
            tr_busy[c] = bus.Busy;
            bus.Stall  = stall_mask[c];
            bus.Start  = start_mask[c];
            if (start_mask[c]) begin
                bus.SrcBase = 32'h99;
                bus.DstBase = 32'h30;
                bus.Length  = 16'd2;
            end
        end
        bus.Stall = 1'b0;
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (bus.Off_RAddr !== 32'h0) begin n_errors++; $display("FAIL reset_off got %h exp 0", bus.Off_RAddr); end
        n_checks++; if (bus.On_WAddr !== 32'h0) begin n_errors++; $display("FAIL reset_wa got %h exp 0", bus.On_WAddr); end
        n_checks++; if (bus.On_WEn !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b exp 0", bus.On_WEn); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
        n_checks++; if (bus.Done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", bus.Done); end
        aclr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] e_we, e_done, e_busy;
        bus.SrcBase = 32'h10; bus.DstBase = 32'h0; bus.Length = 16'd4; bus.Start = 1'b1;
        capture(10, 16'h0, 16'h0);
        e_we = 16'b0000_0000_0011_1100; e_done = 16'b0000_0000_0100_0000; e_busy = 16'b0000_0000_0111_1111;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (tr_we[c] !== e_we[c]) begin n_errors++; $display("FAIL basic_we c%0d got %b exp %b", c, tr_we[c], e_we[c]); end
            n_checks++; if (tr_done[c] !== e_done[c]) begin n_errors++; $display("FAIL basic_done c%0d got %b exp %b", c, tr_done[c], e_done[c]); end
            n_checks++; if (tr_busy[c] !== e_busy[c]) begin n_errors++; $display("FAIL basic_busy c%0d got %b exp %b", c, tr_busy[c], e_busy[c]); end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (tr_off[k+1] !== 32'h10 + k) begin n_errors++; $display("FAIL basic_off k%0d got %h exp %h", k, tr_off[k+1], 32'h10 + k); end
            n_checks++; if (tr_wa[k+2] !== k) begin n_errors++; $display("FAIL basic_wa k%0d got %h exp %h", k, tr_wa[k+2], k); end
            n_checks++; if (tr_q[k+2] !== ram_word(32'h10 + k)) begin n_errors++; $display("FAIL basic_data k%0d got %h exp %h", k, tr_q[k+2], ram_word(32'h10 + k)); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] e_we, e_done;
        logic [31:0] e_off [6];
        logic [31:0] e_wa  [7];
        e_off = '{32'h0, 32'h40, 32'h40, 32'h40, 32'h41, 32'h42};
        e_wa  = '{32'h0, 32'h0, 32'h8, 32'h8, 32'h8, 32'h9, 32'hA};
        bus.SrcBase = 32'h40; bus.DstBase = 32'h8; bus.Length = 16'd3; bus.Start = 1'b1;
        capture(10, 16'b0000_0000_0000_0110, 16'h0);
        e_we = 16'b0000_0000_0110_0100; e_done = 16'b0000_0000_1000_0000;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (tr_we[c] !== e_we[c]) begin n_errors++; $display("FAIL stall_we c%0d got %b exp %b", c, tr_we[c], e_we[c]); end
            n_checks++; if (tr_done[c] !== e_done[c]) begin n_errors++; $display("FAIL stall_done c%0d got %b exp %b", c, tr_done[c], e_done[c]); end
        end
        for (int c = 1; c < 6; c++) begin
            n_checks++; if (tr_off[c] !== e_off[c]) begin n_errors++; $display("FAIL stall_off c%0d got %h exp %h", c, tr_off[c], e_off[c]); end
        end
        for (int c = 2; c < 7; c++) begin
            n_checks++; if (tr_wa[c] !== e_wa[c]) begin n_errors++; $display("FAIL stall_wa c%0d got %h exp %h", c, tr_wa[c], e_wa[c]); end
        end
        n_checks++; if (tr_q[2] !== ram_word(32'h40)) begin n_errors++; $display("FAIL stall_data0 got %h exp %h", tr_q[2], ram_word(32'h40)); end
        n_checks++; if (tr_q[5] !== ram_word(32'h41)) begin n_errors++; $display("FAIL stall_data1 got %h exp %h", tr_q[5], ram_word(32'h41)); end
        n_checks++; if (tr_q[6] !== ram_word(32'h42)) begin n_errors++; $display("FAIL stall_data2 got %h exp %h", tr_q[6], ram_word(32'h42)); end
    endtask

    task automatic test_zero_length();
        logic [15:0] e_done, e_busy;
        bus.SrcBase = 32'h55; bus.DstBase = 32'h3; bus.Length = 16'd0; bus.Start = 1'b1;
        capture(4, 16'h0, 16'h0);
        e_done = 16'b0001; e_busy = 16'b0001;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (tr_we[c] !== 1'b0) begin n_errors++; $display("FAIL zero_we c%0d got %b exp 0", c, tr_we[c]); end
            n_checks++; if (tr_done[c] !== e_done[c]) begin n_errors++; $display("FAIL zero_done c%0d got %b exp %b", c, tr_done[c], e_done[c]); end
            n_checks++; if (tr_busy[c] !== e_busy[c]) begin n_errors++; $display("FAIL zero_busy c%0d got %b exp %b", c, tr_busy[c], e_busy[c]); end
        end
    endtask

    task automatic test_restart_ignored();
        logic [15:0] e_we, e_done, e_busy;
        bus.SrcBase = 32'h20; bus.DstBase = 32'h4; bus.Length = 16'd4; bus.Start = 1'b1;
        // second Start seen during ISSUE, third seen while in DONE
        capture(10, 16'h0, 16'b0000_0000_0100_0010);
        e_we = 16'b0000_0000_0011_1100; e_done = 16'b0000_0000_0100_0000; e_busy = 16'b0000_0000_0111_1111;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (tr_we[c] !== e_we[c]) begin n_errors++; $display("FAIL restart_we c%0d got %b exp %b", c, tr_we[c], e_we[c]); end
            n_checks++; if (tr_done[c] !== e_done[c]) begin n_errors++; $display("FAIL restart_done c%0d got %b exp %b", c, tr_done[c], e_done[c]); end
            n_checks++; if (tr_busy[c] !== e_busy[c]) begin n_errors++; $display("FAIL restart_busy c%0d got %b exp %b", c, tr_busy[c], e_busy[c]); end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (tr_off[k+1] !== 32'h20 + k) begin n_errors++; $display("FAIL restart_off k%0d got %h exp %h", k, tr_off[k+1], 32'h20 + k); end
            n_checks++; if (tr_wa[k+2] !== 32'h4 + k) begin n_errors++; $display("FAIL restart_wa k%0d got %h exp %h", k, tr_wa[k+2], 32'h4 + k); end
        end
    endtask

    task automatic test_async_reset();
        bus.SrcBase = 32'h30; bus.DstBase = 32'h0; bus.Length = 16'd4; bus.Start = 1'b1;
        @(posedge clk); #1; bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.On_WEn !== 1'b1) begin n_errors++; $display("FAIL arst_pre_we got %b exp 1", bus.On_WEn); end
        n_checks++; if (bus.On_WAddr !== 32'h1) begin n_errors++; $display("FAIL arst_pre_wa got %h exp 1", bus.On_WAddr); end
        aclr = 1'b0;
        #1;
        n_checks++; if (bus.On_WEn !== 1'b0) begin n_errors++; $display("FAIL arst_we got %b exp 0", bus.On_WEn); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_errors++; $display("FAIL arst_busy got %b exp 0", bus.Busy); end
        n_checks++; if (bus.Off_RAddr !== 32'h0) begin n_errors++; $display("FAIL arst_off got %h exp 0", bus.Off_RAddr); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.On_WEn !== 1'b0) begin n_errors++; $display("FAIL arst_hold_we c%0d got %b exp 0", c, bus.On_WEn); end
        end
        aclr = 1'b1;
        @(posedge clk); #1;
        bus.SrcBase = 32'h30; bus.DstBase = 32'h0; bus.Length = 16'd4; bus.Start = 1'b1;
        capture(9, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (tr_off[k+1] !== 32'h30 + k) begin n_errors++; $display("FAIL arst_re_off k%0d got %h exp %h", k, tr_off[k+1], 32'h30 + k); end
            n_checks++; if (tr_we[k+2] !== 1'b1) begin n_errors++; $display("FAIL arst_re_we k%0d got %b exp 1", k, tr_we[k+2]); end
            n_checks++; if (tr_wa[k+2] !== k) begin n_errors++; $display("FAIL arst_re_wa k%0d got %h exp %h", k, tr_wa[k+2], k); end
            n_checks++; if (tr_q[k+2] !== ram_word(32'h30 + k)) begin n_errors++; $display("FAIL arst_re_data k%0d got %h exp %h", k, tr_q[k+2], ram_word(32'h30 + k)); end
        end
        n_checks++; if (tr_done[6] !== 1'b1) begin n_errors++; $display("FAIL arst_re_done got %b exp 1", tr_done[6]); end
        n_checks++; if (tr_we[6] !== 1'b0) begin n_errors++; $display("FAIL arst_re_we_end got %b exp 0", tr_we[6]); end
    endtask

    task automatic test_wrap();
        logic [31:0] e_off [4];
        e_off = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        bus.SrcBase = 32'hFFFF_FFFE; bus.DstBase = 32'hC; bus.Length = 16'd4; bus.Start = 1'b1;
        capture(8, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (tr_off[k+1] !== e_off[k]) begin n_errors++; $display("FAIL wrap_off k%0d got %h exp %h", k, tr_off[k+1], e_off[k]); end
            n_checks++; if (tr_wa[k+2] !== 32'hC + k) begin n_errors++; $display("FAIL wrap_wa k%0d got %h exp %h", k, tr_wa[k+2], 32'hC + k); end
            n_checks++; if (tr_q[k+2] !== ram_word(e_off[k])) begin n_errors++; $display("FAIL wrap_data k%0d got %h exp %h", k, tr_q[k+2], ram_word(e_off[k])); end
        end
        n_checks++; if (tr_done[6] !== 1'b1) begin n_errors++; $display("FAIL wrap_done got %b exp 1", tr_done[6]); end
    endtask

`ifdef LOAD_SRC_STRIDE_EN
    task automatic test_stride();
        logic [31:0] e_off [4];
        e_off = '{32'h0, 32'h4, 32'h8, 32'hC};
        bus.SrcStride = 32'd4;
        bus.SrcBase = 32'h0; bus.DstBase = 32'h0; bus.Length = 16'd4; bus.Start = 1'b1;
        capture(8, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (tr_off[k+1] !== e_off[k]) begin n_errors++; $display("FAIL stride_off k%0d got %h exp %h", k, tr_off[k+1], e_off[k]); end
            n_checks++; if (tr_wa[k+2] !== k) begin n_errors++; $display("FAIL stride_wa k%0d got %h exp %h", k, tr_wa[k+2], k); end
            n_checks++; if (tr_q[k+2] !== ram_word(e_off[k])) begin n_errors++; $display("FAIL stride_data k%0d got %h exp %h", k, tr_q[k+2], ram_word(e_off[k])); end
        end
        bus.SrcStride = 32'd1;
    endtask
`endif

    initial begin
        bus.Start   = 1'b0;
        bus.SrcBase = '0;
        bus.DstBase = '0;
        bus.Length  = '0;
        bus.Stall   = 1'b0;
`ifdef LOAD_SRC_STRIDE_EN
        bus.SrcStride = 32'd1;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_zero_length();
        test_restart_ignored();
        test_async_reset();
        test_wrap();
`ifdef LOAD_SRC_STRIDE_EN
        test_stride();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
